// File: rtl/seg_scan_driver_if.sv
// seg_scan_driver_if
// Groups the digit-value inputs and display outputs of seg_scan_driver.
//   seg0..seg7 : 4-bit digit values (seg0 = rightmost digit)
//   dp_mask    : per-digit decimal point enables
//   lz_en      : leading-zero suppression enable
//   seg_out    : shared segment bus, bit 0 = a .. bit 6 = g, bit 7 = dp
//   sel_out    : one-hot digit select, bit i drives digit i
//   frame_tick : one-cycle pulse when a new snapshot has been loaded
// The master modport is the formatting stage or a bench; the slave modport is the driver.
interface seg_scan_driver_if;
    logic [3:0] seg0;
    logic [3:0] seg1;
    logic [3:0] seg2;
    logic [3:0] seg3;
    logic [3:0] seg4;
    logic [3:0] seg5;
    logic [3:0] seg6;
    logic [3:0] seg7;
    logic [7:0] dp_mask;
    logic       lz_en;
    logic [7:0] seg_out;
    logic [7:0] sel_out;
    logic       frame_tick;

    modport master (
        output seg0, seg1, seg2, seg3, seg4, seg5, seg6, seg7, dp_mask, lz_en,
        input  seg_out, sel_out, frame_tick
    );

    modport slave (
        input  seg0, seg1, seg2, seg3, seg4, seg5, seg6, seg7, dp_mask, lz_en,
        output seg_out, sel_out, frame_tick
    );
endinterface

// File: rtl/seg_scan_driver.sv
// seg_scan_driver
// Time-multiplexes eight 4-bit digits onto one 7-segment bus with one-hot selects.
// Each digit slot lasts SCAN_DIV cycles; the first BLANK_CYCLES of it keep every
// digit deselected to avoid ghosting. The inputs are snapshotted once per frame.
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : seg_scan_driver_if.slave (digits, dp_mask, lz_en in; seg_out, sel_out, frame_tick out)
module seg_scan_driver #(
    parameter int SCAN_DIV       = 50000,
    parameter int BLANK_CYCLES   = 500,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit SEL_ACTIVE_LOW = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    seg_scan_driver_if.slave    bus
);

    localparam int         DIV_W   = $clog2(SCAN_DIV);
    localparam logic [7:0] SEG_OFF = {8{SEG_ACTIVE_LOW}};
    localparam logic [7:0] SEL_OFF = {8{SEL_ACTIVE_LOW}};

    function automatic logic [6:0] seg_decode(input logic [3:0] v);
        case (v)
            4'd0:    seg_decode = 7'h3F;
            4'd1:    seg_decode = 7'h06;
            4'd2:    seg_decode = 7'h5B;
            4'd3:    seg_decode = 7'h4F;
            4'd4:    seg_decode = 7'h66;
            4'd5:    seg_decode = 7'h6D;
            4'd6:    seg_decode = 7'h7D;
            4'd7:    seg_decode = 7'h07;
            4'd8:    seg_decode = 7'h7F;
            4'd9:    seg_decode = 7'h6F;
            default: seg_decode = 7'h40;   // dash marks a non-decimal code
        endcase
    endfunction

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [3:0]       snap_q [8];
    logic [7:0]       dp_q;
    logic [7:0]       blank_q, blank_d;
    logic [7:0]       seg_out_q, seg_out_d;
    logic [7:0]       sel_out_q, sel_out_d;
    logic             frame_tick_q;

    logic             div_last;
    logic             frame_load;
    logic             in_blank;
    logic [3:0]       digit_in [8];
    logic [31:0]      digits_flat;

    assign digit_in[0] = bus.seg0;
    assign digit_in[1] = bus.seg1;
    assign digit_in[2] = bus.seg2;
    assign digit_in[3] = bus.seg3;
    assign digit_in[4] = bus.seg4;
    assign digit_in[5] = bus.seg5;
    assign digit_in[6] = bus.seg6;
    assign digit_in[7] = bus.seg7;
    assign digits_flat = {bus.seg7, bus.seg6, bus.seg5, bus.seg4,
                          bus.seg3, bus.seg2, bus.seg1, bus.seg0};

    assign div_last   = (div_cnt_q == DIV_W'(SCAN_DIV - 1));
    assign frame_load = div_last && (idx_q == 3'd7);
    assign in_blank   = (BLANK_CYCLES != 0) && (div_cnt_q < DIV_W'(BLANK_CYCLES));

    assign div_cnt_d = div_last ? '0 : div_cnt_q + 1'b1;
    assign idx_d     = div_last ? idx_q + 3'd1 : idx_q;

    // Suppression flags are derived from the same values being captured, so the
    // displayed frame never mixes old flags with new digits. Digit 0 always shows.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_blank
            if (gi == 0) begin : g_lsd
                assign blank_d[gi] = 1'b0;
            end else begin : g_upper
                assign blank_d[gi] = bus.lz_en && (digits_flat[31:4*gi] == '0);
            end
        end
    endgenerate

    // Output patterns are computed from the current counters and registered,
    // giving the one-cycle latency from div_cnt/idx to the pins.
    always_comb begin
        logic [7:0] seg_pat;
        logic [7:0] sel_pat;
        seg_pat = 8'h00;
        sel_pat = 8'h00;
        if (!in_blank) begin
            sel_pat[idx_q]  = 1'b1;
            seg_pat[6:0]    = blank_q[idx_q] ? 7'h00 : seg_decode(snap_q[idx_q]);
            seg_pat[7]      = dp_q[idx_q];
        end
        seg_out_d = SEG_ACTIVE_LOW ? ~seg_pat : seg_pat;
        sel_out_d = SEL_ACTIVE_LOW ? ~sel_pat : sel_pat;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q    <= '0;
            idx_q        <= 3'd0;
            seg_out_q    <= SEG_OFF;
            sel_out_q    <= SEL_OFF;
            frame_tick_q <= 1'b0;
        end else begin
            div_cnt_q    <= div_cnt_d;
            idx_q        <= idx_d;
            seg_out_q    <= seg_out_d;
            sel_out_q    <= sel_out_d;
            frame_tick_q <= frame_load;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) snap_q[i] <= 4'd0;
            dp_q    <= 8'h00;
            blank_q <= 8'h00;
        end else if (frame_load) begin
            for (int i = 0; i < 8; i++) snap_q[i] <= digit_in[i];
            dp_q    <= bus.dp_mask;
            blank_q <= blank_d;
        end
    end

    assign bus.seg_out    = seg_out_q;
    assign bus.sel_out    = sel_out_q;
    assign bus.frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
module tb_seg_scan_driver;

    localparam int SCAN_DIV     = 8;
    localparam int BLANK_CYCLES = 2;

    typedef struct packed {
        logic [7:0] sel;
        logic [7:0] seg;
        logic       tick;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;
    exp_t sb_q[$];

    seg_scan_driver_if bus ();

    seg_scan_driver #(
        .SCAN_DIV       (SCAN_DIV),
        .BLANK_CYCLES   (BLANK_CYCLES),
        .SEG_ACTIVE_LOW (1'b1),
        .SEL_ACTIVE_LOW (1'b1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] ref_decode(input logic [3:0] v);
        case (v)
            4'd0: return 7'h3F;  4'd1: return 7'h06;  4'd2: return 7'h5B;
            4'd3: return 7'h4F;  4'd4: return 7'h66;  4'd5: return 7'h6D;
            4'd6: return 7'h7D;  4'd7: return 7'h07;  4'd8: return 7'h7F;
            4'd9: return 7'h6F;
            default: return 7'h40;
        endcase
    endfunction

    // Active-low segment byte for digit k of a snapshot (digits packed seg7..seg0).
    function automatic logic [7:0] ref_seg(input logic [31:0] digs, input logic [7:0] dp,
                                           input logic lz, input int k);
        logic [3:0]  v;
        logic [6:0]  p;
        logic [31:0] upper;
        v     = digs[4*k +: 4];
        p     = ref_decode(v);
        upper = digs >> (4 * k);
        if (lz && k > 0 && upper == 32'd0) p = 7'h00;
        return ~{dp[k], p};
    endfunction

    task automatic apply_inputs(input logic [31:0] digs, input logic [7:0] dp, input logic lz);
        bus.seg0 = digs[3:0];   bus.seg1 = digs[7:4];
        bus.seg2 = digs[11:8];  bus.seg3 = digs[15:12];
        bus.seg4 = digs[19:16]; bus.seg5 = digs[23:20];
        bus.seg6 = digs[27:24]; bus.seg7 = digs[31:28];
        bus.dp_mask = dp;
        bus.lz_en   = lz;
    endtask

    // Advances to the negedge where frame_tick is seen, bounded.
    task automatic wait_tick();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.frame_tick !== 1'b1 && n < 70);
        checks++;
        if (bus.frame_tick !== 1'b1) begin
            failures++;
            $display("FAIL wait_tick: frame_tick=%b after %0d cycles, required 1 within 64", bus.frame_tick, n);
        end
    endtask

    // Called at a negedge where a frame starts (frame_tick sample or reset release).
    // Pushes the expected 64 samples of the frame, then pops one per cycle.
    task automatic check_frame(input string name, input logic [31:0] digs, input logic [7:0] dp,
                               input logic lz, input int mid_cycle, input logic [3:0] mid_val);
        exp_t e;
        logic [7:0] onehot;
        int fails_before;
        fails_before = failures;
        for (int i = 0; i < 8; i++) begin
            for (int c = 0; c < SCAN_DIV; c++) begin
                onehot = 8'd1 << i;
                e.sel  = (c < BLANK_CYCLES) ? 8'hFF : ~onehot;
                e.seg  = (c < BLANK_CYCLES) ? 8'hFF : ref_seg(digs, dp, lz, i);
                e.tick = (i == 7 && c == SCAN_DIV - 1);
                sb_q.push_back(e);
            end
        end
        for (int n = 0; n < 8 * SCAN_DIV; n++) begin
            @(negedge clk);
            e = sb_q.pop_front();
            checks += 3;
            if (bus.sel_out !== e.sel) begin
                failures++;
                $display("FAIL %s sel cyc=%0d: got %h, required %h", name, n, bus.sel_out, e.sel);
            end
            if (bus.seg_out !== e.seg) begin
                failures++;
                $display("FAIL %s seg cyc=%0d: got %h, required %h", name, n, bus.seg_out, e.seg);
            end
            if (bus.frame_tick !== e.tick) begin
                failures++;
                $display("FAIL %s tick cyc=%0d: got %b, required %b", name, n, bus.frame_tick, e.tick);
            end
            if (n == mid_cycle) bus.seg0 = mid_val;
        end
        $display("frame %s digits=%h dp=%h lz=%b errors=%0d", name, digs, dp, lz, failures - fails_before);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        apply_inputs(32'h8765_4321, 8'h00, 1'b0);
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (bus.seg_out !== 8'hFF || bus.sel_out !== 8'hFF || bus.frame_tick !== 1'b0) begin
                failures++;
                $display("FAIL reset_hold: got seg=%h sel=%h tick=%b, required FF FF 0",
                         bus.seg_out, bus.sel_out, bus.frame_tick);
            end
        end
        rst_n = 1'b1;
        // First frame shows the all-zero snapshot; tick lands 64 cycles after release.
        check_frame("reset_first", 32'h0, 8'h00, 1'b0, -1, 4'd0);
    endtask

    task automatic test_full_scan();
        check_frame("full_scan", 32'h8765_4321, 8'h00, 1'b0, -1, 4'd0);
    endtask

    task automatic test_snapshot();
        // seg0 changes to 9 during idx 3; this frame must still show 1.
        check_frame("snap_hold", 32'h8765_4321, 8'h00, 1'b0, 3 * SCAN_DIV + 2, 4'd9);
        check_frame("snap_new", 32'h8765_4329, 8'h00, 1'b0, -1, 4'd0);
    endtask

    task automatic test_leading_zeros();
        apply_inputs(32'h0000_1998, 8'h00, 1'b1);
        wait_tick();
        check_frame("lz_1998", 32'h0000_1998, 8'h00, 1'b1, -1, 4'd0);
        apply_inputs(32'h0000_0000, 8'h00, 1'b1);
        wait_tick();
        check_frame("lz_zero", 32'h0000_0000, 8'h00, 1'b1, -1, 4'd0);
        apply_inputs(32'h0000_0000, 8'h81, 1'b1);
        wait_tick();
        check_frame("lz_zero_dp", 32'h0000_0000, 8'h81, 1'b1, -1, 4'd0);
    endtask

    task automatic test_invalid_dp();
        apply_inputs(32'h8765_4C21, 8'h04, 1'b0);
        wait_tick();
        check_frame("invalid_dp", 32'h8765_4C21, 8'h04, 1'b0, -1, 4'd0);
    endtask

    task automatic test_mid_reset();
        // Start from a frame boundary, then move into the show phase of digit 5.
        wait_tick();
        repeat (5 * SCAN_DIV + 3) @(negedge clk);
        checks++;
        if (bus.sel_out !== 8'hDF) begin
            failures++;
            $display("FAIL mid_reset_pre: sel got %h, required DF", bus.sel_out);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.seg_out !== 8'hFF || bus.sel_out !== 8'hFF || bus.frame_tick !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset_async: got seg=%h sel=%h tick=%b, required FF FF 0",
                     bus.seg_out, bus.sel_out, bus.frame_tick);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check_frame("after_reset", 32'h0, 8'h00, 1'b0, -1, 4'd0);
    endtask

    initial begin
        test_reset();
        test_full_scan();
        test_snapshot();
        test_leading_zeros();
        test_invalid_dp();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
